hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 64: maximum MDU_BUSY cycles before forced release.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 SHALL have ports ex_rd  input  5; ex_reg_write, ex_is_load, ex_is_mdu, branch_taken  input  1 each  EX-stage instruction attributes.
REQ-007 SHALL have ports mdu_done  input  1  MDU result valid; dmem_stall  input  1  data memory not ready.
REQ-008 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register enables.
REQ-009 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  insert bubble; mdu_start  output  1  one-cycle MDU launch.
REQ-010 SHALL have ports mdu_err  output  1  sticky timeout flag; stall_cycles  output  16  saturating count; flush_count  output  8  saturating count.

Function
REQ-011 SHALL implement FSM states RUN, MDU_BUSY; enables default 1, flushes and mdu_start default 0.
REQ-012 SHALL detect load-use in RUN: ex_is_load & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-013 SHALL, on load-use, drive pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle; no state change.
REQ-014 SHALL, on branch_taken in RUN with ex_is_mdu=0, drive if_id_flush=1, id_ex_flush=1, pc_en=1; branch overrides load-use.
REQ-015 SHALL, on ex_is_mdu in RUN, pulse mdu_start=1 and go to MDU_BUSY; branch_taken ignored that cycle.
REQ-016 SHALL, in the launch cycle and each MDU_BUSY cycle without done, drive pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1.
REQ-017 SHALL, on mdu_done (or pending done) in MDU_BUSY, drive all enables 1, flushes 0, return to RUN; no relaunch that cycle.
REQ-018 SHALL count MDU_BUSY cycles; reaching MDU_TIMEOUT without done sets mdu_err and releases as in REQ-017.
REQ-019 SHALL, while dmem_stall=1, drive all five enables 0, all flushes 0, mdu_start 0; FSM state and busy count held.
REQ-020 SHALL latch mdu_done arriving during dmem_stall into done_pending; consumed on first cycle after dmem_stall falls.
REQ-021 SHALL suppress load-use and branch actions while dmem_stall=1; re-evaluated when stall drops.
REQ-022 SHALL increment stall_cycles each cycle pc_en=0, saturating at 16'hFFFF.
REQ-023 SHALL increment flush_count each cycle any flush output is 1, saturating at 8'hFF.
REQ-024 SHALL ignore mdu_done in RUN; mdu_err cleared only by reset.

Reset
REQ-025 SHALL, while rst_n=0, force state RUN, busy count 0, done_pending 0, mdu_err 0, counters 0, mdu_start 0.
REQ-026 SHALL abort an in-flight MDU wait on reset; enables follow REQ-011 defaults immediately after release.

Structure
REQ-027 SHALL place the state enum and MDU_TIMEOUT default in shared package hazard_pkg.
REQ-028 SHALL instantiate sub-module hazard_sat_cnt (parameterised width, saturating, enable input) for both counters.

Verification
REQ-029 SHALL check: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_en=0, id_ex_flush=1, stall_cycles=1.
REQ-030 SHALL check: same load-use plus branch_taken=1 -> pc_en=1, if_id_flush=id_ex_flush=1, flush_count=1.
REQ-031 SHALL check: ex_is_mdu=1, mdu_done 4 cycles later -> mdu_start single pulse, 5 cycles pc_en=0, RUN after done.
REQ-032 SHALL check: mdu_done pulses during 3-cycle dmem_stall -> enables 0 throughout, release on first non-stall cycle.
REQ-033 SHALL check: MDU_TIMEOUT=8, no mdu_done -> mdu_err=1 after 8 busy cycles, enables 1, mdu_err stays 1 until rst_n=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the controller FSM encoding and the MDU timeout default.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_e;

  localparam int MDU_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with enable.
// Holds at all-ones once reached.
module hazard_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// multi-cycle MDU wait with timeout, and data-memory stall freeze.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic        ex_is_mdu,
  input  logic        branch_taken,
  input  logic        mdu_done,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mdu_start,
  output logic        mdu_err,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  localparam int CW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MDU_TIMEOUT - 1);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] busy_cnt, busy_cnt_d;
  logic          done_pending, done_pending_d;
  logic          mdu_err_d;
  logic          start_c;
  logic          load_use;
  logic          done;
  logic          tmo;

  assign load_use = ex_is_load && ex_reg_write
                 && (ex_rd != 5'd0)
                 && ((id_use_rs1 && (id_rs1 == ex_rd))
                  || (id_use_rs2 && (id_rs2 == ex_rd)));

  assign done = mdu_done || done_pending;
  assign tmo  = (busy_cnt == TMO_LAST);

  always_comb begin
    state_d        = state_q;
    busy_cnt_d     = busy_cnt;
    done_pending_d = done_pending;
    mdu_err_d      = mdu_err;
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    mem_wb_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    start_c        = 1'b0;
    if (dmem_stall) begin
      // Whole pipe frozen; a done pulse seen now is kept for later.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      if ((state_q == MDU_BUSY) && mdu_done) begin
        done_pending_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_is_mdu) begin
            start_c        = 1'b1;
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            id_ex_en       = 1'b0;
            ex_mem_flush   = 1'b1;
            busy_cnt_d     = '0;
            done_pending_d = 1'b0;
            state_d        = MDU_BUSY;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MDU_BUSY: begin
          if (done || tmo) begin
            state_d        = RUN;
            busy_cnt_d     = '0;
            done_pending_d = 1'b0;
            if (!done) begin
              mdu_err_d = 1'b1;
            end
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            busy_cnt_d   = busy_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      busy_cnt     <= '0;
      done_pending <= 1'b0;
      mdu_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_cnt     <= busy_cnt_d;
      done_pending <= done_pending_d;
      mdu_err      <= mdu_err_d;
    end
  end

  assign mdu_start = start_c && rst_n;

  hazard_sat_cnt #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!pc_en),
    .count (stall_cycles)
  );

  hazard_sat_cnt #(.W(8)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_id_flush || id_ex_flush || ex_mem_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: rule-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_reg_write, ex_is_load, ex_is_mdu, branch_taken;
  logic        mdu_done, dmem_stall;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic        mdu_start, mdu_err;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_is_load   (ex_is_load),
    .ex_is_mdu    (ex_is_mdu),
    .branch_taken (branch_taken),
    .mdu_done     (mdu_done),
    .dmem_stall   (dmem_stall),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mdu_start    (mdu_start),
    .mdu_err      (mdu_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit m_busy, m_pend, m_err;
  int m_cnt, m_sc, m_fc;
  logic [4:0] e_en;
  logic [2:0] e_fl;
  logic       e_start, e_launch, e_rel;

  function automatic bit hazard(input logic [4:0] rd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic u1,
                                input logic u2);
    logic [4:0] src [2];
    logic       use_src [2];
    bit hit = 0;
    src[0] = r1; src[1] = r2;
    use_src[0] = u1; use_src[1] = u2;
    for (int i = 0; i < 2; i++)
      if (use_src[i] && src[i] == rd && rd != 0) hit = 1;
    return hit;
  endfunction

  always_comb begin
    e_en = 5'b11111;
    e_fl = 3'b000;
    e_start = 0;
    e_launch = 0;
    e_rel = 0;
    if (dmem_stall) begin
      e_en = 5'b00000;
    end else if (!m_busy) begin
      if (ex_is_mdu) begin
        e_launch = 1;
        e_start = 1;
        e_en = 5'b00011;
        e_fl = 3'b001;
      end else if (branch_taken) begin
        e_fl = 3'b110;
      end else if (ex_is_load && ex_reg_write &&
                   hazard(ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2)) begin
        e_en = 5'b00111;
        e_fl = 3'b010;
      end
    end else begin
      e_rel = mdu_done || m_pend || (m_cnt + 1 >= TMO);
      if (!e_rel) begin
        e_en = 5'b00011;
        e_fl = 3'b001;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_pend <= 0; m_err <= 0;
      m_cnt <= 0; m_sc <= 0; m_fc <= 0;
    end else begin
      if (!e_en[4]) m_sc <= (m_sc >= 65535) ? 65535 : m_sc + 1;
      if (|e_fl) m_fc <= (m_fc >= 255) ? 255 : m_fc + 1;
      if (dmem_stall) begin
        if (m_busy && mdu_done) m_pend <= 1;
      end else if (e_launch) begin
        m_busy <= 1; m_cnt <= 0; m_pend <= 0;
      end else if (m_busy) begin
        if (e_rel) begin
          m_busy <= 0; m_pend <= 0;
          if (!(mdu_done || m_pend)) m_err <= 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_ctl",
            int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush,
                  mdu_start, mdu_err}),
            int'({e_en, e_fl, e_start, m_err}));
      check("model_stall_cycles", int'(stall_cycles), m_sc);
      check("model_flush_count", int'(flush_count), m_fc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0; ex_is_mdu = 0;
    branch_taken = 0; mdu_done = 0; dmem_stall = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    ex_is_mdu = 1;
    rst_n = 0;
    #1;
    check("rst_mdu_start", int'(mdu_start), 0);
    repeat (2) @(posedge clk);
    idle();
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_state", int'({pc_en, id_ex_en, mdu_err, ex_mem_flush}), 'b1100);
    check("rst_counters", int'({stall_cycles, flush_count}), 0);
    nxt();
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_is_load = 1; ex_reg_write = 1; ex_rd = rd;
    id_rs1 = 5; id_use_rs1 = 1;
  endtask

  int lows, starts;

  initial begin
    idle();
    do_reset();

    // load-use stall
    set_lu(5);
    @(negedge clk);
    check("lu_pc_en", int'(pc_en), 0);
    check("lu_if_id_en", int'(if_id_en), 0);
    check("lu_id_ex_flush", int'(id_ex_flush), 1);
    nxt(); idle();
    @(negedge clk);
    check("lu_stall_cycles", int'(stall_cycles), 1);
    check("lu_released", int'(pc_en), 1);
    nxt(); set_lu(0);
    @(negedge clk);
    check("lu_rd0", int'(pc_en), 1);
    nxt(); set_lu(5); id_use_rs1 = 0;
    @(negedge clk);
    check("lu_unused_rs1", int'(pc_en), 1);
    id_rs2 = 5; id_use_rs2 = 1;
    nxt();
    @(negedge clk);
    check("lu_rs2", int'(id_ex_flush), 1);
    nxt(); ex_reg_write = 0;
    @(negedge clk);
    check("lu_no_write", int'(pc_en), 1);
    nxt(); ex_reg_write = 1; dmem_stall = 1;
    @(negedge clk);
    check("lu_dmem_stall", int'({pc_en, mem_wb_en, id_ex_flush}), 0);
    nxt(); idle();

    // branch overrides load-use
    do_reset();
    set_lu(5); branch_taken = 1;
    @(negedge clk);
    check("br_pc_en", int'(pc_en), 1);
    check("br_flushes", int'({if_id_flush, id_ex_flush}), 3);
    nxt(); idle();
    @(negedge clk);
    check("br_flush_count", int'(flush_count), 1);

    // MDU launch, done four cycles into the busy wait
    do_reset();
    lows = 0; starts = 0;
    for (int c = 0; c <= 5; c++) begin
      idle();
      if (c == 0) begin ex_is_mdu = 1; branch_taken = 1; end
      if (c == 5) begin mdu_done = 1; ex_is_mdu = 1; end
      @(negedge clk);
      if (!pc_en) lows++;
      if (mdu_start) starts++;
      if (c == 0) check("mdu_launch_flush", int'({if_id_flush, ex_mem_flush}), 1);
      nxt();
    end
    check("mdu_pc_low_cycles", lows, 5);
    check("mdu_start_pulses", starts, 1);
    idle();
    @(negedge clk);
    check("mdu_back_run", int'({pc_en, id_ex_en, ex_mem_flush}), 'b110);
    check("mdu_stall_cycles", int'(stall_cycles), 5);
    nxt();

    // done arrives while data memory is stalled
    do_reset();
    lows = 0;
    for (int c = 0; c <= 4; c++) begin
      idle();
      if (c == 0) ex_is_mdu = 1;
      if (c >= 2) dmem_stall = 1;
      if (c == 3) mdu_done = 1;
      @(negedge clk);
      if (c >= 2 && {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush} == 0) lows++;
      nxt();
    end
    check("ds_frozen_cycles", lows, 3);
    idle();
    @(negedge clk);
    check("ds_release", int'({pc_en, id_ex_en, ex_mem_flush}), 'b110);
    nxt();
    @(negedge clk);
    check("ds_run_pc_en", int'(pc_en), 1);
    nxt();

    // timeout without done
    do_reset();
    ex_is_mdu = 1;
    nxt(); idle();
    for (int c = 1; c < TMO; c++) begin
      @(negedge clk);
      if (c == TMO - 1) check("tmo_still_busy", int'(pc_en), 0);
      nxt();
    end
    @(negedge clk);
    check("tmo_release", int'({pc_en, mdu_err}), 'b10);
    nxt(); mdu_done = 1;
    @(negedge clk);
    check("tmo_err_set", int'({mdu_err, pc_en}), 'b11);
    nxt(); idle();
    repeat (3) nxt();
    @(negedge clk);
    check("tmo_err_sticky", int'(mdu_err), 1);
    rst_n = 0;
    #1;
    check("tmo_err_reset", int'(mdu_err), 0);
    do_reset();

    // flush counter saturation
    branch_taken = 1;
    repeat (260) nxt();
    idle();
    @(negedge clk);
    check("flush_sat", int'(flush_count), 255);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
